mod_addsub_stream: RTL and testbench

MOD_ADDSUB_STREAM -- requirements
Module: mod_addsub_stream

---
 rtl/mod_addsub_pkg.sv | 23 ++
 rtl/mod_addsub_buf.sv | 33 +++
 rtl/mod_addsub_stream.sv | 135 +++++++++++++
 tb/tb_mod_addsub_stream.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mod_addsub_pkg.sv
// Shared types and default sizes for the streaming modular add/subtract datapath.
package mod_addsub_pkg;

  localparam int DEF_K = 128;
  localparam int DEF_N = 32;

  typedef enum logic {
    MODE_ADD = 1'b0,
    MODE_SUB = 1'b1
  } mode_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;

  // A one-word operand still needs a one-bit word index.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mod_addsub_buf.sv
// Candidate-word storage: two N x K arrays sharing one write port and one read port.
module mod_addsub_buf
  import mod_addsub_pkg::*;
#(
  parameter int K  = DEF_K,
  parameter int N  = DEF_N,
  parameter int AW = cnt_width(N)
) (
  input  logic          clk,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [K-1:0]  wdata_a_i,
  input  logic [K-1:0]  wdata_b_i,
  input  logic [AW-1:0] raddr_i,
  output logic [K-1:0]  rdata_a_o,
  output logic [K-1:0]  rdata_b_o
);

  logic [K-1:0] mem_a [N];
  logic [K-1:0] mem_b [N];

  // NOTE: no reset on the arrays so they map onto RAM; every entry is written before it is read.
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_a[waddr_i] <= wdata_a_i;
      mem_b[waddr_i] <= wdata_b_i;
    end
  end

  assign rdata_a_o = mem_a[raddr_i];
  assign rdata_b_o = mem_b[raddr_i];

endmodule

// File: rtl/mod_addsub_stream.sv
// Word-serial modular add/subtract: loads N operand words, computes both the raw and
// the reduced candidate per word, then streams out whichever the final flags select.
module mod_addsub_stream
  import mod_addsub_pkg::*;
#(
  parameter int K = DEF_K,
  parameter int N = DEF_N
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         op_start,
  input  logic [1:0]   op_mode,
  input  logic [K-1:0] in_x,
  input  logic [K-1:0] in_y,
  input  logic [K-1:0] in_m,
  input  logic         in_valid,
  output logic         op_busy,
  output logic [K-1:0] out_result,
  output logic         out_valid,
  output logic         out_last
);

  localparam int            CW       = cnt_width(N);
  localparam logic [CW-1:0] LAST_IDX = CW'(N - 1);

  state_e        state_q, state_d;
  mode_e         mode_q, mode_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          carry_q, carry_d;
  logic          borrow_q, borrow_d;

  logic [K:0]    sum_p;   // raw candidate (s or d) with its flag bit on top
  logic [K:0]    sum_r;   // reduced candidate (r or t) with its flag bit on top
  logic          wr_en;
  logic          sel_red;
  logic [K-1:0]  rd_p, rd_r;

  always_comb begin
    if (mode_q == MODE_SUB) begin
      sum_p = {1'b0, in_x} - {1'b0, in_y} - (K+1)'(borrow_q);
      sum_r = {1'b0, sum_p[K-1:0]} + {1'b0, in_m} + (K+1)'(carry_q);
    end else begin
      sum_p = {1'b0, in_x} + {1'b0, in_y} + (K+1)'(carry_q);
      sum_r = {1'b0, sum_p[K-1:0]} - {1'b0, in_m} - (K+1)'(borrow_q);
    end
  end

  assign wr_en = (state_q == ST_LOAD) && in_valid;

  // NOTE: every variable gets its hold value first so no path through the case infers a latch.
  always_comb begin
    state_d  = state_q;
    mode_d   = mode_q;
    cnt_d    = cnt_q;
    carry_d  = carry_q;
    borrow_d = borrow_q;
    case (state_q)
      ST_IDLE: begin
        if (op_start) begin
          state_d  = ST_LOAD;
          cnt_d    = '0;
          carry_d  = 1'b0;
          borrow_d = 1'b0;
          mode_d   = (op_mode == 2'b01) ? MODE_SUB : MODE_ADD;
        end
      end
      ST_LOAD: begin
        if (in_valid) begin
          if (mode_q == MODE_SUB) begin
            borrow_d = sum_p[K];
            carry_d  = sum_r[K];
          end else begin
            carry_d  = sum_p[K];
            borrow_d = sum_r[K];
          end
          if (cnt_q == LAST_IDX) begin
            cnt_d   = '0;
            state_d = ST_DRAIN;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      ST_DRAIN: begin
        if (cnt_q == LAST_IDX) begin
          cnt_d   = '0;
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      mode_q   <= MODE_ADD;
      cnt_q    <= '0;
      carry_q  <= 1'b0;
      borrow_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      mode_q   <= mode_d;
      cnt_q    <= cnt_d;
      carry_q  <= carry_d;
      borrow_q <= borrow_d;
    end
  end

  mod_addsub_buf #(
    .K (K),
    .N (N),
    .AW(CW)
  ) u_buf (
    .clk      (clk),
    .we_i     (wr_en),
    .waddr_i  (cnt_q),
    .wdata_a_i(sum_p[K-1:0]),
    .wdata_b_i(sum_r[K-1:0]),
    .raddr_i  (cnt_q),
    .rdata_a_o(rd_p),
    .rdata_b_o(rd_r)
  );

  // After the last word the flags are final: ADD reduces when x+y >= m, SUB corrects when x < y.
  assign sel_red    = (mode_q == MODE_SUB) ? borrow_q : (carry_q | ~borrow_q);
  assign out_valid  = (state_q == ST_DRAIN);
  assign out_last   = out_valid && (cnt_q == LAST_IDX);
  assign op_busy    = (state_q != ST_IDLE);
  assign out_result = out_valid ? (sel_red ? rd_r : rd_p) : '0;

endmodule

// File: tb/tb_mod_addsub_stream.sv
// Bench for mod_addsub_stream: a K=8/N=2 instance for directed vectors and a default-size
// instance for long randomized operations, both checked against whole-operand arithmetic.
module tb_mod_addsub_stream;
  import mod_addsub_pkg::*;

  localparam int SK = 8;
  localparam int SN = 2;
  localparam int LK = DEF_K;
  localparam int LN = DEF_N;

  typedef logic [4095:0] wide_t;

  typedef struct {
    logic [1:0]  mode;
    logic [15:0] x;
    logic [15:0] y;
    logic [15:0] m;
    logic [15:0] exp;
  } vec_t;

  logic clk, rst;

  logic          s_start, s_inv, s_busy, s_ov, s_last;
  logic [1:0]    s_mode;
  logic [SK-1:0] s_x, s_y, s_m, s_res;

  logic          l_start, l_inv, l_busy, l_ov, l_last;
  logic [1:0]    l_mode;
  logic [LK-1:0] l_x, l_y, l_m, l_res;

  int n_checks = 0;
  int n_fail   = 0;

  mod_addsub_stream #(.K(SK), .N(SN)) dut_s (
    .clk(clk), .rst(rst), .op_start(s_start), .op_mode(s_mode),
    .in_x(s_x), .in_y(s_y), .in_m(s_m), .in_valid(s_inv),
    .op_busy(s_busy), .out_result(s_res), .out_valid(s_ov), .out_last(s_last)
  );

  mod_addsub_stream dut_l (
    .clk(clk), .rst(rst), .op_start(l_start), .op_mode(l_mode),
    .in_x(l_x), .in_y(l_y), .in_m(l_m), .in_valid(l_inv),
    .op_busy(l_busy), .out_result(l_res), .out_valid(l_ov), .out_last(l_last)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, got timeout required completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // Reference: whole-operand modular arithmetic on w = K*N bits.
  function automatic wide_t model(input bit big, input logic [1:0] mode,
                                  input wide_t x, input wide_t y, input wide_t m);
    logic [4096:0] mask, acc;
    int w;
    w    = big ? LK * LN : SK * SN;
    mask = (4097'(1) << w) - 4097'(1);
    if (mode == 2'b01) begin
      acc = {1'b0, x} - {1'b0, y};
      if (x < y) acc = acc + {1'b0, m};
    end else begin
      acc = {1'b0, x} + {1'b0, y};
      if (acc >= {1'b0, m}) acc = acc - {1'b0, m};
    end
    acc = acc & mask;
    return acc[4095:0];
  endfunction

  function automatic wide_t rnd_wide();
    wide_t v;
    for (int i = 0; i < 128; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  function automatic logic [127:0] word(input bit big, input wide_t v, input int i);
    if (big) return v[i*LK +: LK];
    return {120'b0, v[i*SK +: SK]};
  endfunction

  task automatic drive(input bit big, input bit st, input logic [1:0] md,
                       input logic [127:0] xw, input logic [127:0] yw,
                       input logic [127:0] mw, input bit iv);
    if (big) begin
      l_start = st; l_mode = md; l_x = xw; l_y = yw; l_m = mw; l_inv = iv;
    end else begin
      s_start = st; s_mode = md; s_x = xw[7:0]; s_y = yw[7:0]; s_m = mw[7:0]; s_inv = iv;
    end
  endtask

  task automatic sample(input bit big, output logic ov, output logic lst,
                        output logic bsy, output logic [127:0] rs);
    if (big) begin
      ov = l_ov; lst = l_last; bsy = l_busy; rs = l_res;
    end else begin
      ov = s_ov; lst = s_last; bsy = s_busy; rs = {120'b0, s_res};
    end
  endtask

  task automatic idle_cycle();
    @(posedge clk); #1;
  endtask

  // Entered and left at 1 time unit after a rising edge, in a cycle where the DUT is idle,
  // so two calls in a row exercise a start in the same cycle op_busy falls.
  task automatic run_op(input bit big, input logic [1:0] mode, input wide_t x, input wide_t y,
                        input wide_t m, input wide_t exp, input bit gaps, input bit spam,
                        input int abort_at);
    int n, i, cyc, nw;
    bit iv, st, done;
    logic ov, lst, bsy;
    logic [127:0] rs;
    n = big ? LN : SN;

    // Coincident in_valid carries garbage that must not be taken as word 0.
    drive(big, 1'b1, mode, rnd128(), rnd128(), rnd128(), 1'b1);
    @(posedge clk); #1;
    sample(big, ov, lst, bsy, rs);
    check("busy_load", {127'b0, bsy}, 128'd1);

    i = 0;
    cyc = 0;
    while (i < n && cyc < 4 * n) begin
      iv = !gaps || (cyc % 2 == 0);
      st = spam && (cyc % 3 == 1);
      if (iv) drive(big, st, 2'b01, word(big, x, i), word(big, y, i), word(big, m, i), 1'b1);
      else    drive(big, st, 2'b01, rnd128(), rnd128(), rnd128(), 1'b0);
      if (iv) i++;
      cyc++;
      @(posedge clk); #1;
    end
    check("load_words", 128'(i), 128'(n));

    nw = 0;
    done = 1'b0;
    for (int c = 0; c < n + 3 && !done; c++) begin
      drive(big, spam && (c % 2 == 0), 2'b01, rnd128(), rnd128(), rnd128(), spam);
      sample(big, ov, lst, bsy, rs);
      if (ov) begin
        check($sformatf("word%0d", nw), rs, word(big, exp, nw));
        check($sformatf("last%0d", nw), {127'b0, lst}, {127'b0, (nw == n - 1)});
        if (nw == abort_at) begin
          rst = 1'b1;
          #1;
          sample(big, ov, lst, bsy, rs);
          check("abort_valid", {127'b0, ov}, 128'd0);
          check("abort_result", rs, 128'd0);
          check("abort_busy", {127'b0, bsy}, 128'd0);
          check("abort_last", {127'b0, lst}, 128'd0);
          drive(big, 1'b0, 2'b00, '0, '0, '0, 1'b0);
          @(posedge clk); #1;
          rst = 1'b0;
          for (int q = 0; q < 4; q++) begin
            @(posedge clk); #1;
            sample(big, ov, lst, bsy, rs);
            check("post_abort_valid", {127'b0, ov}, 128'd0);
          end
          return;
        end
        if (lst) begin
          check("busy_at_last", {127'b0, bsy}, 128'd1);
          done = 1'b1;
        end
        nw++;
      end else begin
        check("result_zero_idle", rs, 128'd0);
      end
      @(posedge clk); #1;
    end
    check("word_count", 128'(nw), 128'(n));

    drive(big, 1'b0, 2'b00, '0, '0, '0, 1'b0);
    sample(big, ov, lst, bsy, rs);
    check("busy_after_last", {127'b0, bsy}, 128'd0);
    check("valid_after_last", {127'b0, ov}, 128'd0);
  endtask

  initial begin
    vec_t  vt[8];
    wide_t x, y, m, e, x2, y2, m2, e2;
    logic  ov, lst, bsy;
    logic [127:0] rs;

    vt[0] = '{2'b00, 16'h00C8, 16'h0064, 16'h00FB, 16'h0031};
    vt[1] = '{2'b01, 16'h0005, 16'h000A, 16'h00FB, 16'h00F6};
    vt[2] = '{2'b01, 16'h0042, 16'h0042, 16'h00FB, 16'h0000};
    vt[3] = '{2'b00, 16'hFFF0, 16'hFFF0, 16'hFFF1, 16'hFFEF};
    vt[4] = '{2'b00, 16'h00FA, 16'h0001, 16'h00FB, 16'h0000};
    vt[5] = '{2'b10, 16'h00C8, 16'h0064, 16'h00FB, 16'h0031};
    vt[6] = '{2'b11, 16'h0010, 16'h0020, 16'h00FB, 16'h0030};
    vt[7] = '{2'b01, 16'h0100, 16'h0001, 16'h00FB, 16'h00FF};

    rst = 1'b1;
    drive(1'b0, 1'b0, 2'b00, '0, '0, '0, 1'b0);
    drive(1'b1, 1'b0, 2'b00, '0, '0, '0, 1'b0);
    #1;
    for (int b = 0; b < 2; b++) begin
      sample(b[0], ov, lst, bsy, rs);
      check("reset_valid", {127'b0, ov}, 128'd0);
      check("reset_last", {127'b0, lst}, 128'd0);
      check("reset_busy", {127'b0, bsy}, 128'd0);
      check("reset_result", rs, 128'd0);
    end
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    idle_cycle();

    for (int v = 0; v < 8; v++) begin
      run_op(1'b0, vt[v].mode, wide_t'(vt[v].x), wide_t'(vt[v].y), wide_t'(vt[v].m),
             wide_t'(vt[v].exp), 1'b0, 1'b0, -1);
      idle_cycle();
    end

    // Back-to-back on the small instance, the second with bubbles and ignored starts.
    run_op(1'b0, vt[0].mode, wide_t'(vt[0].x), wide_t'(vt[0].y), wide_t'(vt[0].m),
           wide_t'(vt[0].exp), 1'b0, 1'b0, -1);
    run_op(1'b0, vt[1].mode, wide_t'(vt[1].x), wide_t'(vt[1].y), wide_t'(vt[1].m),
           wide_t'(vt[1].exp), 1'b1, 1'b1, -1);
    idle_cycle();

    for (int r = 0; r < 20; r++) begin
      logic [1:0] md;
      md = 2'($urandom_range(0, 3));
      x = wide_t'(16'($urandom));
      y = wide_t'(16'($urandom));
      m = wide_t'(16'($urandom_range(1, 65535)));
      run_op(1'b0, md, x, y, m, model(1'b0, md, x, y, m), r[0], r[1], -1);
      if (r[2]) idle_cycle();
    end
    idle_cycle();

    // Default size: ADD with bubbles and stray starts, then the same operands gap-free.
    x = rnd_wide(); y = rnd_wide(); m = rnd_wide();
    m[4095] = 1'b1; x[4095] = 1'b0; y[4095] = 1'b0;
    e = model(1'b1, 2'b00, x, y, m);
    run_op(1'b1, 2'b00, x, y, m, e, 1'b1, 1'b1, -1);
    idle_cycle();
    run_op(1'b1, 2'b00, x, y, m, e, 1'b0, 1'b0, -1);
    idle_cycle();

    x = rnd_wide(); y = rnd_wide(); m = rnd_wide();
    run_op(1'b1, 2'b01, x, y, m, model(1'b1, 2'b01, x, y, m), 1'b1, 1'b0, -1);
    idle_cycle();
    run_op(1'b1, 2'b00, x, y, m, model(1'b1, 2'b00, x, y, m), 1'b0, 1'b1, -1);
    idle_cycle();

    // Abort mid-drain, then a fresh operation must complete correctly.
    run_op(1'b1, 2'b00, x, y, m, model(1'b1, 2'b00, x, y, m), 1'b0, 1'b0, 10);
    x2 = rnd_wide(); y2 = rnd_wide(); m2 = rnd_wide();
    run_op(1'b1, 2'b01, x2, y2, m2, model(1'b1, 2'b01, x2, y2, m2), 1'b0, 1'b0, -1);

    // Back-to-back on the default-size instance.
    e  = model(1'b1, 2'b01, y2, x2, m2);
    e2 = model(1'b1, 2'b00, x2, x2, m2);
    run_op(1'b1, 2'b01, y2, x2, m2, e, 1'b0, 1'b0, -1);
    run_op(1'b1, 2'b00, x2, x2, m2, e2, 1'b1, 1'b0, -1);
    idle_cycle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
